// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - logic-analyser capture sequencer: sample strobe and dense channel packing
// Optional trigger qualification in ARM is enabled by defining CAPTURE_SEQ_TRIGGER_EN.

module capture_sequencer #(
  parameter int DIV_WIDTH = 8,
  parameter int NCH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [NCH-1:0]       chan_mask,
  input  logic [NCH-1:0]       sample_in,
`ifdef CAPTURE_SEQ_TRIGGER_EN
  input  logic [NCH-1:0]       trig_mask,
  input  logic [NCH-1:0]       trig_value,
`endif
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [15:0]          out_data,
  output logic                 sample_strobe,
  output logic                 running,
  output logic                 overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_FLUSH,
    S_ERROR
  } state_t;

  state_t               state;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_q;
  logic [NCH-1:0]       mask_q;
  logic [31:0]          acc;
  logic [4:0]           fill;

  logic [15:0]          packed_bits;
  logic [4:0]           n_bits;
  logic [31:0]          acc_sum;
  logic [4:0]           fill_sum;
  logic [4:0]           fill_after;
  logic                 word_done;
  logic                 tick;
  logic                 capture;
  logic                 lose;

  // Enabled channels are gathered in ascending index order into the low bits.
  always_comb begin
    packed_bits = '0;
    n_bits      = '0;
    for (int i = 0; i < NCH; i++) begin
      if (mask_q[i]) begin
        packed_bits[n_bits[3:0]] = sample_in[i];
        n_bits = n_bits + 5'd1;
      end
    end
  end

  always_comb begin
    acc_sum   = acc | ({16'd0, packed_bits} << fill);
    fill_sum  = fill + n_bits;
    word_done = fill_sum[4];
    tick      = (cnt == '0);
    capture   = (state == S_RUN) && tick;
`ifdef CAPTURE_SEQ_TRIGGER_EN
    sample_strobe = tick && ((state == S_RUN) || (state == S_ARM));
    if ((state == S_ARM) && tick && !stop &&
        ((sample_in & trig_mask) == (trig_value & trig_mask)))
      capture = 1'b1;
`else
    sample_strobe = tick && (state == S_RUN);
`endif
    lose       = capture && word_done && out_valid && !out_ready;
    fill_after = capture ? (word_done ? fill_sum - 5'd16 : fill_sum) : fill;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      div_q     <= '0;
      mask_q    <= '0;
      acc       <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      running   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      // A completed word may load in the same cycle the held one transfers.
      if (capture && !lose) begin
        if (word_done) begin
          out_data  <= acc_sum[15:0];
          out_valid <= 1'b1;
          acc       <= acc_sum >> 16;
          fill      <= fill_sum - 5'd16;
        end else begin
          acc  <= acc_sum;
          fill <= fill_sum;
        end
      end

      case (state)
        S_IDLE: begin
          if (start && !stop && (chan_mask != '0)) begin
            state    <= S_ARM;
            running  <= 1'b1;
            div_q    <= divisor;
            mask_q   <= chan_mask;
            acc      <= '0;
            fill     <= '0;
            overflow <= 1'b0;
            cnt      <= '0;
          end
        end
        S_ARM: begin
          if (stop) begin
            state   <= S_IDLE;
            running <= 1'b0;
          end else begin
`ifdef CAPTURE_SEQ_TRIGGER_EN
            cnt <= tick ? div_q : cnt - 1'b1;
            if (capture)
              state <= S_RUN;
`else
            state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          cnt <= tick ? div_q : cnt - 1'b1;
          if (stop) begin
            running <= 1'b0;
            state   <= (fill_after != '0) ? S_FLUSH : S_IDLE;
          end
        end
        S_FLUSH: begin
          if (stop) begin
            state <= S_IDLE;
            acc   <= '0;
            fill  <= '0;
          end else if (!out_valid || out_ready) begin
            // Bits above the fill count are already zero, giving the padding.
            out_data  <= acc[15:0];
            out_valid <= 1'b1;
            acc       <= '0;
            fill      <= '0;
            state     <= S_IDLE;
          end
        end
        S_ERROR: begin
          if (stop) begin
            state    <= S_IDLE;
            overflow <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          running <= 1'b0;
        end
      endcase

      if (lose) begin
        overflow <= 1'b1;
        state    <= S_ERROR;
        running  <= 1'b0;
      end
    end
  end

endmodule
